ctx_branch_sequencer: RTL and testbench

- Consumer end of the predicate interface. It reads the condition box's registered predicate (Reg_O) and combinational predicate (Comb_O).
- It turns them into the array's context counter (CCNT): sequential fetch, unconditional jump, predicated branch, halt.
- It sits between the context-control memory and every PE/PBox context memory, and gates their EN_I.

---
 rtl/ctx_branch_sequencer_pkg.sv | 59 +++++
 rtl/ctx_branch_sequencer_ccu_next_addr.sv | 105 ++++++++++
 rtl/ctx_branch_sequencer.sv | 142 ++++++++++++++
 tb/tb_ctx_branch_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ctx_branch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ctx_branch_sequencer_pkg
// Shared definitions for the context branch sequencer (CCU):
//   - default widths of the context counter and opcode field
//   - opcode constants of the control context word
//   - bit offsets of the control word fields (op / pred_sel / invert / target)
//   - FSM state encodings
// Optional feature macro: CCU_HW_LOOP_EN (enables the SETLOOP/LOOP opcodes).
// -----------------------------------------------------------------------------
package ctx_branch_sequencer_pkg;

  // Default widths; the modules take these as parameter defaults.
  localparam int unsigned CCU_CCNT_WIDTH = 8;
  localparam int unsigned CCU_OP_WIDTH   = 3;

  // Opcodes of the control word. 6 and 7 are reserved and execute as NEXT.
  // SETLOOP/LOOP only have an effect when CCU_HW_LOOP_EN is defined.
  localparam int unsigned OPC_NEXT    = 32'd0;
  localparam int unsigned OPC_JUMP    = 32'd1;
  localparam int unsigned OPC_BRANCH  = 32'd2;
  localparam int unsigned OPC_HALT    = 32'd3;
  localparam int unsigned OPC_SETLOOP = 32'd4;
  localparam int unsigned OPC_LOOP    = 32'd5;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ccu_state_e;

  // Control word layout, MSB to LSB: op | pred_sel | invert | target.
  // Offsets are functions of the widths so every instance can derive its own.
  function automatic int unsigned ccu_target_l(input int unsigned ccnt_w);
    ccu_target_l = 32'd0;
  endfunction

  function automatic int unsigned ccu_target_h(input int unsigned ccnt_w);
    ccu_target_h = ccnt_w - 32'd1;
  endfunction

  function automatic int unsigned ccu_invert(input int unsigned ccnt_w);
    ccu_invert = ccnt_w;
  endfunction

  function automatic int unsigned ccu_predsel(input int unsigned ccnt_w);
    ccu_predsel = ccnt_w + 32'd1;
  endfunction

  function automatic int unsigned ccu_op_l(input int unsigned ccnt_w);
    ccu_op_l = ccnt_w + 32'd2;
  endfunction

  function automatic int unsigned ccu_op_h(input int unsigned ccnt_w,
                                           input int unsigned op_w);
    ccu_op_h = ccnt_w + 32'd2 + op_w - 32'd1;
  endfunction

endpackage

// File: rtl/ctx_branch_sequencer_ccu_next_addr.sv
// -----------------------------------------------------------------------------
// ccu_next_addr
// Purely combinational next-address / branch-decision logic of the sequencer.
// Decodes the control word at the current context address and produces the
// address of the next context plus a halt flag.
// Optional feature macro: CCU_HW_LOOP_EN adds the loop counter interface.
//
// Ports:
//   ccnt          in   current context address
//   ctrl_word     in   control word fetched at ccnt
//   pred_reg      in   registered predicate from the condition box
//   pred_comb     in   combinational predicate from the condition box
//   loop_cnt      in   current loop counter            (CCU_HW_LOOP_EN only)
//   loop_we       out  loop counter update strobe       (CCU_HW_LOOP_EN only)
//   loop_cnt_nxt  out  loop counter value to store      (CCU_HW_LOOP_EN only)
//   ccnt_nxt      out  next context address
//   halt          out  the word is HALT
// -----------------------------------------------------------------------------
module ccu_next_addr
  import ctx_branch_sequencer_pkg::*;
#(
  parameter int unsigned CCNT_WIDTH = CCU_CCNT_WIDTH,
  parameter int unsigned OP_WIDTH   = CCU_OP_WIDTH,
  parameter int unsigned CTRL_WIDTH = OP_WIDTH + 2 + CCNT_WIDTH
) (
  input  logic [CCNT_WIDTH-1:0] ccnt,
  input  logic [CTRL_WIDTH-1:0] ctrl_word,
  input  logic                  pred_reg,
  input  logic                  pred_comb,
`ifdef CCU_HW_LOOP_EN
  input  logic [CCNT_WIDTH-1:0] loop_cnt,
  output logic                  loop_we,
  output logic [CCNT_WIDTH-1:0] loop_cnt_nxt,
`endif
  output logic [CCNT_WIDTH-1:0] ccnt_nxt,
  output logic                  halt
);

  localparam int unsigned OP_H     = ccu_op_h(CCNT_WIDTH, OP_WIDTH);
  localparam int unsigned OP_L     = ccu_op_l(CCNT_WIDTH);
  localparam int unsigned PREDSEL  = ccu_predsel(CCNT_WIDTH);
  localparam int unsigned INVERT   = ccu_invert(CCNT_WIDTH);
  localparam int unsigned TARGET_H = ccu_target_h(CCNT_WIDTH);
  localparam int unsigned TARGET_L = ccu_target_l(CCNT_WIDTH);

  logic [OP_WIDTH-1:0]   op_s;
  logic                  pred_sel_s;
  logic                  invert_s;
  logic [CCNT_WIDTH-1:0] target_s;
  logic [CCNT_WIDTH-1:0] inc_s;
  logic                  pred_s;

  assign op_s       = ctrl_word[OP_H:OP_L];
  assign pred_sel_s = ctrl_word[PREDSEL];
  assign invert_s   = ctrl_word[INVERT];
  assign target_s   = ctrl_word[TARGET_H:TARGET_L];

  // Sequential successor; the addition wraps modulo 2^CCNT_WIDTH by width.
  assign inc_s  = ccnt + CCNT_WIDTH'(1);

  // Effective predicate: selected source, optionally inverted.
  assign pred_s = (pred_sel_s ? pred_comb : pred_reg) ^ invert_s;

  // Opcode decode into next address, halt flag and loop counter update.
  always_comb begin
    ccnt_nxt = inc_s;
    halt     = 1'b0;
`ifdef CCU_HW_LOOP_EN
    loop_we      = 1'b0;
    loop_cnt_nxt = loop_cnt;
`endif
    case (op_s)
      OP_WIDTH'(OPC_NEXT):   ccnt_nxt = inc_s;
      OP_WIDTH'(OPC_JUMP):   ccnt_nxt = target_s;
      OP_WIDTH'(OPC_BRANCH): ccnt_nxt = pred_s ? target_s : inc_s;
      OP_WIDTH'(OPC_HALT): begin
        // The address holds so CCNT_O keeps pointing at the HALT word.
        ccnt_nxt = ccnt;
        halt     = 1'b1;
      end
`ifdef CCU_HW_LOOP_EN
      OP_WIDTH'(OPC_SETLOOP): begin
        ccnt_nxt     = inc_s;
        loop_we      = 1'b1;
        loop_cnt_nxt = target_s;
      end
      OP_WIDTH'(OPC_LOOP): begin
        // A count of N loads makes the body run N+1 times: the back-jump is
        // taken while the counter is nonzero, and the exit leaves it at 0.
        if (loop_cnt != {CCNT_WIDTH{1'b0}}) begin
          ccnt_nxt     = target_s;
          loop_we      = 1'b1;
          loop_cnt_nxt = loop_cnt - CCNT_WIDTH'(1);
        end else begin
          ccnt_nxt     = inc_s;
          loop_we      = 1'b0;
          loop_cnt_nxt = loop_cnt;
        end
      end
`endif
      default:               ccnt_nxt = inc_s;
    endcase
  end

endmodule

// File: rtl/ctx_branch_sequencer.sv
// -----------------------------------------------------------------------------
// ctx_branch_sequencer
// Context counter (CCNT) sequencer of the array. Consumes the condition box's
// registered and combinational predicates and steps the context address by
// sequential fetch, unconditional jump, predicated branch or halt. It gates
// the enable of every PE/PBox context memory.
// Optional feature macro: CCU_HW_LOOP_EN (hardware loop counter with
// SETLOOP/LOOP opcodes; without it those opcodes execute as NEXT).
//
// Ports:
//   CLK_I         in   clock
//   RST_I         in   synchronous, active-high reset
//   EN_I          in   global enable; low freezes all state
//   START_I       in   start request, honoured in IDLE only
//   START_ADDR_I  in   first context address
//   CTRL_WORD_I   in   control word at CCNT_O (same cycle, from control memory)
//   PRED_REG_I    in   registered predicate from the condition box
//   PRED_COMB_I   in   combinational predicate from the condition box
//   CCNT_O        out  current context address (registered)
//   CTX_EN_O      out  context enable, high in RUN while EN_I is high
//   BUSY_O        out  sequencer is in RUN
//   DONE_O        out  one-cycle pulse after HALT executes
// -----------------------------------------------------------------------------
module ctx_branch_sequencer
  import ctx_branch_sequencer_pkg::*;
#(
  parameter int unsigned CCNT_WIDTH = CCU_CCNT_WIDTH,
  parameter int unsigned OP_WIDTH   = CCU_OP_WIDTH,
  parameter int unsigned CTRL_WIDTH = OP_WIDTH + 2 + CCNT_WIDTH
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  EN_I,
  input  logic                  START_I,
  input  logic [CCNT_WIDTH-1:0] START_ADDR_I,
  input  logic [CTRL_WIDTH-1:0] CTRL_WORD_I,
  input  logic                  PRED_REG_I,
  input  logic                  PRED_COMB_I,
  output logic [CCNT_WIDTH-1:0] CCNT_O,
  output logic                  CTX_EN_O,
  output logic                  BUSY_O,
  output logic                  DONE_O
);

  ccu_state_e            state_r;
  logic [CCNT_WIDTH-1:0] ccnt_r;
  logic                  busy_r;
  logic                  done_r;
  logic [CCNT_WIDTH-1:0] ccnt_nxt_s;
  logic                  halt_s;
`ifdef CCU_HW_LOOP_EN
  logic [CCNT_WIDTH-1:0] loop_cnt_r;
  logic [CCNT_WIDTH-1:0] loop_cnt_nxt_s;
  logic                  loop_we_s;
`endif

  ccu_next_addr #(
    .CCNT_WIDTH (CCNT_WIDTH),
    .OP_WIDTH   (OP_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_next_addr (
    .ccnt         (ccnt_r),
    .ctrl_word    (CTRL_WORD_I),
    .pred_reg     (PRED_REG_I),
    .pred_comb    (PRED_COMB_I),
`ifdef CCU_HW_LOOP_EN
    .loop_cnt     (loop_cnt_r),
    .loop_we      (loop_we_s),
    .loop_cnt_nxt (loop_cnt_nxt_s),
`endif
    .ccnt_nxt     (ccnt_nxt_s),
    .halt         (halt_s)
  );

  // Sequencer FSM with its counter, loop counter and state-decoded flags.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r    <= ST_IDLE;
      ccnt_r     <= {CCNT_WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef CCU_HW_LOOP_EN
      loop_cnt_r <= {CCNT_WIDTH{1'b0}};
`endif
    end else if (EN_I) begin
      case (state_r)
        ST_IDLE: begin
          // The first context executes in the cycle after START_I.
          if (START_I) begin
            ccnt_r  <= START_ADDR_I;
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          ccnt_r <= ccnt_nxt_s;
`ifdef CCU_HW_LOOP_EN
          if (loop_we_s) begin
            loop_cnt_r <= loop_cnt_nxt_s;
          end else begin
            loop_cnt_r <= loop_cnt_r;
          end
`endif
          if (halt_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          // START_I is not looked at here, so a request coinciding with the
          // DONE pulse is dropped.
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: fall back to a quiet IDLE.
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end else begin
      // EN_I low: every register holds, including a pending DONE.
      state_r <= state_r;
    end
  end

  assign CCNT_O   = ccnt_r;
  assign BUSY_O   = busy_r;
  // EN_I gating is combinational so the contexts stop in the very cycle EN_I
  // drops, and a pending DONE pulse is shown only once EN_I is back.
  assign CTX_EN_O = busy_r & EN_I;
  assign DONE_O   = done_r & EN_I;

endmodule

// File: tb/tb_ctx_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ctx_branch_sequencer
// Directed bench for ctx_branch_sequencer. A small control memory model feeds
// CTRL_WORD_I from CCNT_O. Each stimulus cycle pushes the expected outputs for
// that cycle into a queue; a monitor pops and compares on the falling edge.
// Expectations follow CCU_HW_LOOP_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_ctx_branch_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic [7:0]  start_addr;
  logic [12:0] ctrl_word;
  logic        pred_reg;
  logic        pred_comb;
  logic [7:0]  ccnt;
  logic        ctx_en;
  logic        busy;
  logic        done;

  logic [12:0] ctrl_mem [256];

  typedef struct packed {
    int unsigned idx;
    logic [7:0]  ccnt;
    logic        ctx_en;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   step_no;

  ctx_branch_sequencer dut (
    .CLK_I        (clk),
    .RST_I        (rst),
    .EN_I         (en),
    .START_I      (start),
    .START_ADDR_I (start_addr),
    .CTRL_WORD_I  (ctrl_word),
    .PRED_REG_I   (pred_reg),
    .PRED_COMB_I  (pred_comb),
    .CCNT_O       (ccnt),
    .CTX_EN_O     (ctx_en),
    .BUSY_O       (busy),
    .DONE_O       (done)
  );

  assign ctrl_word = ctrl_mem[ccnt];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] cw(input logic [2:0] op, input logic sel,
                                     input logic inv, input logic [7:0] tgt);
    return {op, sel, inv, tgt};
  endfunction

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic r, input logic e, input logic s,
                      input logic [7:0] addr, input logic pc, input logic pr,
                      input logic [7:0] e_ccnt, input logic e_ctx,
                      input logic e_busy, input logic e_done);
    exp_t x;
    rst        = r;
    en         = e;
    start      = s;
    start_addr = addr;
    pred_comb  = pc;
    pred_reg   = pr;
    x.idx      = step_no;
    x.ccnt     = e_ccnt;
    x.ctx_en   = e_ctx;
    x.busy     = e_busy;
    x.done     = e_done;
    step_no    = step_no + 1;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cyc(input logic [7:0] e_ccnt);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, e_ccnt, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle_cyc(input logic [7:0] e_ccnt);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, e_ccnt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_cyc(input logic [7:0] addr, input logic [7:0] e_ccnt);
    step(1'b0, 1'b1, 1'b1, addr, 1'b0, 1'b0, e_ccnt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic done_cyc(input logic [7:0] e_ccnt);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, e_ccnt, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        checks = checks + 4;
        if (ccnt !== m.ccnt) begin
          errors = errors + 1;
          $display("FAIL ccnt step %0d: got %02h expected %02h", m.idx, ccnt, m.ccnt);
        end
        if (ctx_en !== m.ctx_en) begin
          errors = errors + 1;
          $display("FAIL ctx_en step %0d: got %0b expected %0b", m.idx, ctx_en, m.ctx_en);
        end
        if (busy !== m.busy) begin
          errors = errors + 1;
          $display("FAIL busy step %0d: got %0b expected %0b", m.idx, busy, m.busy);
        end
        if (done !== m.done) begin
          errors = errors + 1;
          $display("FAIL done step %0d: got %0b expected %0b", m.idx, done, m.done);
        end
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    for (int i = 0; i < 256; i++) ctrl_mem[i] = 13'h0000;
    ctrl_mem[8'h12] = cw(3'd2, 1'b1, 1'b0, 8'h40);  // BRANCH comb -> 0x40
    ctrl_mem[8'h40] = cw(3'd3, 1'b0, 1'b0, 8'h00);  // HALT
    ctrl_mem[8'h13] = cw(3'd1, 1'b0, 1'b0, 8'hFE);  // JUMP 0xFE
    ctrl_mem[8'hFE] = cw(3'd7, 1'b0, 1'b0, 8'h99);  // reserved -> NEXT
    ctrl_mem[8'h00] = cw(3'd1, 1'b0, 1'b0, 8'h05);  // JUMP 0x05
    ctrl_mem[8'h05] = cw(3'd6, 1'b1, 1'b1, 8'h77);  // reserved -> NEXT
    ctrl_mem[8'h07] = cw(3'd3, 1'b0, 1'b0, 8'h00);  // HALT
    ctrl_mem[8'h20] = cw(3'd4, 1'b0, 1'b0, 8'h02);  // SETLOOP 2
    ctrl_mem[8'h22] = cw(3'd5, 1'b0, 1'b0, 8'h21);  // LOOP -> 0x21
    ctrl_mem[8'h23] = cw(3'd3, 1'b0, 1'b0, 8'h00);  // HALT

    rst = 1'b1; en = 1'b1; start = 1'b0; start_addr = 8'h00;
    pred_reg = 1'b0; pred_comb = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, start at 0x10, sequential fetch, taken BRANCH, HALT.
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    start_cyc(8'h10, 8'h00);
    run_cyc(8'h10);
    run_cyc(8'h11);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0);
    run_cyc(8'h40);
    // START_I during DONE must be dropped.
    step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1);
    idle_cyc(8'h40);
    idle_cyc(8'h40);

    // Not-taken BRANCH, JUMP, reserved opcodes, wrap, EN_I freeze, HALT.
    start_cyc(8'h12, 8'h40);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0);
    run_cyc(8'h13);
    run_cyc(8'hFE);
    run_cyc(8'hFF);
    run_cyc(8'h00);
    run_cyc(8'h05);
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 1'b0);
    run_cyc(8'h06);
    run_cyc(8'h07);
    // DONE deferred while EN_I is low.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
    done_cyc(8'h07);
    idle_cyc(8'h07);

    // Inverted registered predicate, reset mid-RUN.
    ctrl_mem[8'h12] = cw(3'd2, 1'b0, 1'b1, 8'h40);
    start_cyc(8'h12, 8'h07);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h13, 1'b1, 1'b1, 1'b0);
    idle_cyc(8'h00);
    start_cyc(8'h12, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0);
    run_cyc(8'h40);
    done_cyc(8'h40);
    idle_cyc(8'h40);

    // Hardware loop (or straight-line without the loop feature).
    start_cyc(8'h20, 8'h40);
    run_cyc(8'h20);
`ifdef CCU_HW_LOOP_EN
    for (int k = 0; k < 3; k++) begin
      run_cyc(8'h21);
      run_cyc(8'h22);
    end
`else
    run_cyc(8'h21);
    run_cyc(8'h22);
`endif
    run_cyc(8'h23);
    done_cyc(8'h23);
    idle_cyc(8'h23);

    for (int k = 0; k < 5; k++) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
